// File: rtl/toggle_event_rx.sv
// -----------------------------------------------------------------------------
// toggle_event_rx
//
// Receiver for a toggle-encoded event line driven by a T flip-flop sender.
// Every level change on tog_in is one event. Each recovered event produces a
// one-cycle strobe on evt_pulse and is queued in a saturating pending counter.
// The pending counter is drained by a valid/ready handshake. A wrapping total
// counter and a sticky overflow flag are also maintained.
//
// Optional build macro:
//   TOGGLE_EVENT_RX_SYNC_EN  defined   -> two-flop synchronizer in front of the
//                                          edge detector (tog_in may be async);
//                                          evt_pulse one cycle later.
//                            undefined -> single sampling flop; tog_in must be
//                                          synchronous to clk.
//
// Parameters:
//   PEND_W  width of the pending-event counter (saturates at 2^PEND_W-1)
//   CNT_W   width of the total-event counter (wraps modulo 2^CNT_W)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   tog_in     in   toggle-encoded event line
//   clr        in   synchronous clear of counters and overflow flag
//   evt_ready  in   consumer accepts one pending event
//   evt_valid  out  at least one event pending
//   evt_pulse  out  one-cycle strobe per detected event
//   pend_cnt   out  number of pending events
//   total_cnt  out  events detected since reset/clr (wrapping)
//   overflow   out  sticky: an event was dropped because pend_cnt was full
// -----------------------------------------------------------------------------
module toggle_event_rx #(
  parameter int PEND_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tog_in,
  input  logic              clr,
  input  logic              evt_ready,
  output logic              evt_valid,
  output logic              evt_pulse,
  output logic [PEND_W-1:0] pend_cnt,
  output logic [CNT_W-1:0]  total_cnt,
  output logic              overflow
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  logic              s2;
  logic              prev;
  logic              pop;
  logic              dropped;
  logic [PEND_W-1:0] pend_nxt;
  logic [CNT_W-1:0]  total_nxt;
  logic              ovf_nxt;

  // Saturating increment: returns {dropped, new_value}. When the counter is
  // already full the value holds and the dropped bit is raised.
  function automatic logic [PEND_W:0] sat_inc(input logic [PEND_W-1:0] cur);
    if (cur == PEND_MAX)
      return {1'b1, cur};
    else
      return {1'b0, cur + PEND_W'(1)};
  endfunction

  // ---- Sampling stage(s): tog_in -> s2 ----
`ifdef TOGGLE_EVENT_RX_SYNC_EN
  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= tog_in;
      s2 <= s1;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2 <= 1'b0;
    end else begin
      s2 <= tog_in;
    end
  end
`endif

  // ---- Edge detection: prev tracks s2; clr deliberately leaves it alone so
  // clearing never fabricates an event ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else begin
      prev <= s2;
    end
  end

  // Both operands are flops, so the strobe is glitch-free.
  assign evt_pulse = s2 ^ prev;

  assign evt_valid = (pend_cnt != '0);
  assign pop       = evt_valid & evt_ready;

  always_comb begin
    pend_nxt  = pend_cnt;
    total_nxt = total_cnt;
    ovf_nxt   = overflow;
    dropped   = 1'b0;
    if (clr) begin
      pend_nxt  = '0;
      total_nxt = '0;
      ovf_nxt   = 1'b0;
    end else begin
      if (evt_pulse)
        total_nxt = total_cnt + CNT_W'(1);
      // An event and a pop in the same cycle cancel, even when full.
      case ({evt_pulse, pop})
        2'b10: begin
          {dropped, pend_nxt} = sat_inc(pend_cnt);
          if (dropped)
            ovf_nxt = 1'b1;
        end
        2'b01:   pend_nxt = pend_cnt - PEND_W'(1);
        default: pend_nxt = pend_cnt;
      endcase
    end
  end

  // ---- Counter / flag registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cnt  <= '0;
      total_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      pend_cnt  <= pend_nxt;
      total_cnt <= total_nxt;
      overflow  <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_toggle_event_rx.sv
// Bench for toggle_event_rx: two instances share one stimulus stream,
// a default-size one (A) and a small one (B: PEND_W=2, CNT_W=3) that reaches
// saturation and wrap quickly. Expected pulse cycles go into per-instance
// queues; a negedge monitor pops and checks them whenever evt_pulse is seen.
module tb_toggle_event_rx;

`ifdef TOGGLE_EVENT_RX_SYNC_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tog_in = 1'b0;
  logic clr = 1'b0;
  logic evt_ready = 1'b0;

  logic       valid_a, pulse_a, ovf_a;
  logic [3:0] pend_a;
  logic [7:0] total_a;
  logic       valid_b, pulse_b, ovf_b;
  logic [1:0] pend_b;
  logic [2:0] total_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int qa[$];
  int qb[$];

  toggle_event_rx #(.PEND_W(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .tog_in(tog_in), .clr(clr), .evt_ready(evt_ready),
    .evt_valid(valid_a), .evt_pulse(pulse_a), .pend_cnt(pend_a),
    .total_cnt(total_a), .overflow(ovf_a)
  );

  toggle_event_rx #(.PEND_W(2), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .tog_in(tog_in), .clr(clr), .evt_ready(evt_ready),
    .evt_valid(valid_b), .evt_pulse(pulse_b), .pend_cnt(pend_b),
    .total_cnt(total_b), .overflow(ovf_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_a(input string tag, input int pend, input int total,
                       input int valid, input int ovf);
    chk({tag, " a.pend"},  32'(pend_a),  32'(pend));
    chk({tag, " a.total"}, 32'(total_a), 32'(total));
    chk({tag, " a.valid"}, 32'(valid_a), 32'(valid));
    chk({tag, " a.ovf"},   32'(ovf_a),   32'(ovf));
  endtask

  task automatic chk_b(input string tag, input int pend, input int total,
                       input int valid, input int ovf);
    chk({tag, " b.pend"},  32'(pend_b),  32'(pend));
    chk({tag, " b.total"}, 32'(total_b), 32'(total));
    chk({tag, " b.valid"}, 32'(valid_b), 32'(valid));
    chk({tag, " b.ovf"},   32'(ovf_b),   32'(ovf));
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Flip the line (called just after an edge) and record when the pulse
  // must be visible: after edge cyc+1 (+1 more with the synchronizer).
  task automatic toggle();
    tog_in = ~tog_in;
    qa.push_back(cyc + 1 + LAT);
    qb.push_back(cyc + 1 + LAT);
  endtask

  // Monitor: every observed pulse must match the oldest expected cycle.
  always @(negedge clk) begin
    if (pulse_a) begin
      if (qa.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a.pulse: unexpected pulse at cycle %0d, got 1, expected 0", cyc);
      end else begin
        chk("a.pulse_cycle", 32'(cyc), 32'(qa.pop_front()));
      end
    end
    if (pulse_b) begin
      if (qb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b.pulse: unexpected pulse at cycle %0d, got 1, expected 0", cyc);
      end else begin
        chk("b.pulse_cycle", 32'(cyc), 32'(qb.pop_front()));
      end
    end
  end

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst a.pulse", 32'(pulse_a), 0);
    chk_a("rst", 0, 0, 0, 0);
    chk_b("rst", 0, 0, 0, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk_a("post-rst", 0, 0, 0, 0);

    // Three events, no consumer
    for (int i = 0; i < 3; i++) begin
      toggle();
      tick(4);
    end
    chk_a("3evt", 3, 3, 1, 0);
    chk_b("3evt", 3, 3, 1, 0);

    // Drain with ready held for 4 cycles; the last one finds nothing pending
    evt_ready = 1'b1;
    chk("drain0 a.pend", 32'(pend_a), 3);
    tick(1); chk("drain1 a.pend", 32'(pend_a), 2); chk("drain1 b.pend", 32'(pend_b), 2);
    tick(1); chk("drain2 a.pend", 32'(pend_a), 1);
    tick(1); chk_a("drain3", 0, 3, 0, 0);
    tick(1); chk_a("drain4", 0, 3, 0, 0); chk_b("drain4", 0, 3, 0, 0);
    evt_ready = 1'b0;

    // Four events: B saturates at 3 and drops one
    for (int i = 0; i < 4; i++) begin
      toggle();
      tick(4);
    end
    chk_a("ovf", 4, 7, 1, 0);
    chk_b("ovf", 3, 7, 1, 1);
    evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
    chk_a("ovf-pop", 3, 7, 1, 0);
    chk_b("ovf-pop", 2, 7, 1, 1);
    clr = 1'b1; tick(1); clr = 1'b0;
    chk_a("clr", 0, 0, 0, 0);
    chk_b("clr", 0, 0, 0, 0);
    tick(3);
    chk_a("clr-quiet", 0, 0, 0, 0);

    // Event coincident with a pop leaves pend_cnt unchanged
    toggle(); tick(4);
    toggle(); tick(4);
    chk_a("pend2", 2, 2, 1, 0);
    toggle(); tick(1 + LAT);
    evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
    tick(2);
    chk_a("coinc", 2, 3, 1, 0);
    chk_b("coinc", 2, 3, 1, 0);
    toggle(); tick(4);
    chk_b("full", 3, 4, 1, 0);
    toggle(); tick(1 + LAT);
    evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
    tick(2);
    chk_a("coinc-full", 3, 5, 1, 0);
    chk_b("coinc-full", 3, 5, 1, 0);

    // Wrap of the 3-bit total with the consumer always ready
    clr = 1'b1; tick(1); clr = 1'b0;
    evt_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      toggle();
      tick(4);
    end
    evt_ready = 1'b0;
    chk_a("wrap", 0, 9, 0, 0);
    chk_b("wrap", 0, 1, 0, 0);

    // Asynchronous reset with an event in flight
    clr = 1'b1; tick(1); clr = 1'b0;
    toggle(); tick(4);
    toggle(); tick(4);
    chk_a("pre-rst", 2, 2, 1, 0);
    toggle();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst a.pulse", 32'(pulse_a), 0);
    chk_a("midrst", 0, 0, 0, 0);
    chk_b("midrst", 0, 0, 0, 0);
    qa.delete();
    qb.delete();
    tog_in = 1'b1;
    tick(2);
    rst_n = 1'b1;
    qa.push_back(cyc + 1 + LAT);
    qb.push_back(cyc + 1 + LAT);
    tick(5);
    chk_a("rst-rel", 1, 1, 1, 0);
    chk_b("rst-rel", 1, 1, 1, 0);

    // Every expected pulse must have been seen
    chk("a.missing_pulses", 32'(qa.size()), 0);
    chk("b.missing_pulses", 32'(qb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/toggle_event_rx.md
Name: toggle_event_rx

Overview:
- Receiving end of a toggle-encoded event line, as driven by a T flip-flop sender (each sender T pulse flips the line once).
- Recovers one event per level change and exposes it as a one-cycle pulse.
- Buffers recovered events as a pending count and hands them off through a valid/ready handshake.
- Keeps a running total and a sticky overflow flag; sits between a TFF-based event source and a downstream consumer.

Parameters:
- PEND_W, 4, width of pending-event counter; holds at most 2^PEND_W-1 events.
- CNT_W, 8, width of total-event counter; wraps modulo 2^CNT_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- tog_in  in  1  toggle-encoded event line; every 0->1 or 1->0 change is one event.
- clr  in  1  synchronous clear of counters and flag.
- evt_ready  in  1  consumer accepts one pending event.
- evt_valid  out  1  at least one event pending.
- evt_pulse  out  1  one-cycle strobe per detected event.
- pend_cnt  out  PEND_W  events pending.
- total_cnt  out  CNT_W  events detected since reset/clr.
- overflow  out  1  sticky; set when an event is dropped.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All internal flops clear to 0: sync stages, previous-level register, counters, overflow.
  - Outputs during and immediately after reset: evt_pulse=0, evt_valid=0, pend_cnt=0, total_cnt=0, overflow=0.
  - If tog_in is 1 at reset release, that level counts as one event, detected at the normal latency.
- Edge detection:
  - s2 is the last sampling stage; prev <= s2 every cycle.
  - evt_pulse = s2 XOR prev, decoded from registers only, so it is glitch-free and high for exactly one cycle per change.
- Latency (tog_in changes before rising edge k):
  - With the synchronizer: evt_pulse high from edge k+1 to edge k+2.
  - Without it: evt_pulse high from edge k to edge k+1.
- Input rule:
  - tog_in must hold each level for at least 2 cycles with the synchronizer, 1 cycle without.
  - Faster toggling may lose events; this is not required to be detected.
- Handshake:
  - evt_valid = (pend_cnt != 0).
  - pop = evt_valid & evt_ready.
  - evt_ready while evt_valid=0 has no effect.
- Pending counter update:
  - event and no pop, pend_cnt < max: +1.
  - pop and no event: -1.
  - event and pop in the same cycle: unchanged (any level, including max).
  - event, no pop, pend_cnt == max: event dropped, pend_cnt holds, overflow <= 1.
- total_cnt:
  - +1 on every detected event, including dropped ones.
  - Wraps from 2^CNT_W-1 to 0; no flag on wrap.
- overflow: stays 1 until clr or reset.
- clr (synchronous, highest priority over event and pop):
  - pend_cnt, total_cnt and overflow go to 0 at the next edge.
  - An event or pop coincident with clr is discarded.
  - Sync stages and prev are not affected, so no spurious event follows clr.
- Reset mid-operation: all state clears immediately regardless of pending count or a pulse in flight. After release, detection resumes from prev=0.

Optional Feature:
- Macro: TOGGLE_EVENT_RX_SYNC_EN.
- Defined: two-flop synchronizer in front of edge detection (s1 <= tog_in, s2 <= s1). Intended for tog_in from an unrelated clock or an asynchronous source. Latency: edge k+1.
- Undefined: single sampling flop (s2 <= tog_in). Only legal when tog_in is driven synchronously from clk. Latency: edge k.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, tog_in=0, evt_ready=0; toggle tog_in 3 times, 4 cycles apart -> 3 single-cycle evt_pulse at the required latency; pend_cnt=3, total_cnt=3, evt_valid=1, overflow=0.
- From pend_cnt=3, hold evt_ready=1 for 4 cycles -> pend_cnt 3,2,1,0; evt_valid falls when pend_cnt reaches 0; the 4th ready cycle has no effect.
- PEND_W=2, evt_ready=0, 4 toggles -> pend_cnt=3, total_cnt=4, overflow=1. Then one pop -> pend_cnt=2, overflow stays 1. Then clr -> pend_cnt=0, total_cnt=0, overflow=0.
- pend_cnt=2, toggle timed so evt_pulse coincides with evt_ready=1 -> pend_cnt stays 2, total_cnt +1. Repeat at pend_cnt=max with PEND_W=2 -> pend_cnt stays 3, overflow stays 0.
- CNT_W=3, 9 toggles with evt_ready=1 -> total_cnt=1, pend_cnt=0.
- pend_cnt=2 with a toggle in flight, assert rst_n=0 between edges -> all outputs 0 immediately. Release with tog_in=1 -> exactly one event detected, pend_cnt=1.
